axi_burst_arbiter: RTL and testbench

- N-to-1 arbiter for one crossbar output channel (W or R beat stream) shared by SENDER_NUM senders.
- Picks the least-recently-served valid sender and locks the grant for a whole burst, up to and including the beat with last=1.
- Muxes that sender's valid, data and last to the output and routes the output ready back to it.
- Keeps a full LRU rank table; it does not use a simple round-robin pointer.

---
 rtl/axi_burst_arbiter.sv | 178 +++++++++++++++++
 tb/tb_axi_burst_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_arbiter.sv
// ---------------------------------------------------------------------------
// axi_burst_arbiter
//
// N-to-1 burst arbiter for one crossbar output beat channel (W or R stream).
// The least-recently-served valid sender wins. Its grant is then locked until
// the beat carrying last=1 has transferred. While locked, the owner's valid,
// last and data are muxed to the output, and the downstream ready is routed
// back to the owner only.
//
// A full LRU rank table is kept: rank 0 is the highest priority, and the
// ranks always form a permutation of 0..SENDER_NUM-1. When a burst
// completes, the owner drops to the lowest priority (SENDER_NUM-1). Every
// sender that ranked below the owner moves up by one.
//
// Handshake: a beat transfers on a rising edge where out_valid && out_ready.
// While the channel is locked, req_ready[g] equals out_ready, so the owner
// sees the same transfer. A sender must hold its beat stable until it
// transfers. The owner may drop valid mid-burst; the grant holds regardless.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous, active-high reset
//   req_valid  per-sender beat valid
//   req_last   per-sender last-beat flag
//   req_data   packed payloads, sender i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready  per-sender ready (only the owner can see it high)
//   out_valid  muxed valid
//   out_last   muxed last
//   out_data   muxed payload
//   out_ready  downstream ready
//   grant      one-hot owner, 0 when idle
//   grant_id   binary owner index, 0 when idle
//   busy       burst locked (this is the FSM state: 0=IDLE, 1=BUSY)
// ---------------------------------------------------------------------------
module axi_burst_arbiter #(
    parameter int SENDER_NUM = 4,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_WIDTH  = $clog2(SENDER_NUM)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [SENDER_NUM-1:0]            req_valid,
    input  logic [SENDER_NUM-1:0]            req_last,
    input  logic [SENDER_NUM*DATA_WIDTH-1:0] req_data,
    output logic [SENDER_NUM-1:0]            req_ready,
    output logic                             out_valid,
    output logic                             out_last,
    output logic [DATA_WIDTH-1:0]            out_data,
    input  logic                             out_ready,
    output logic [SENDER_NUM-1:0]            grant,
    output logic [IDX_WIDTH-1:0]             grant_id,
    output logic                             busy
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_WIDTH-1:0] g_q, g_d;
    logic [IDX_WIDTH-1:0] rank_q [SENDER_NUM];
    logic [IDX_WIDTH-1:0] rank_d [SENDER_NUM];

    logic                  win_found;
    logic [IDX_WIDTH-1:0]  win_idx;
    logic [IDX_WIDTH-1:0]  win_rank;

    logic                  own_valid;
    logic                  own_last;
    logic [DATA_WIDTH-1:0] own_data;
    logic [IDX_WIDTH-1:0]  own_rank;
    logic                  done;

    // Lowest-rank valid sender. The ranks are a permutation, so the winner is
    // unique and no tie-break is needed.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_rank  = '0;
        for (int i = 0; i < SENDER_NUM; i++) begin
            if (req_valid[i] && (!win_found || rank_q[i] < win_rank)) begin
                win_found = 1'b1;
                win_idx   = IDX_WIDTH'(i);
                win_rank  = rank_q[i];
            end
        end
    end

    // Owner mux. This is purely combinational from g_q, so a locked burst
    // adds no latency per beat.
    always_comb begin
        own_valid = 1'b0;
        own_last  = 1'b0;
        own_data  = '0;
        own_rank  = '0;
        for (int i = 0; i < SENDER_NUM; i++) begin
            if (g_q == IDX_WIDTH'(i)) begin
                own_valid = req_valid[i];
                own_last  = req_last[i];
                own_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                own_rank  = rank_q[i];
            end
        end
    end

    assign done = (state_q == BUSY) && own_valid && out_ready && own_last;

    // Next state and outputs. Every output is zero in IDLE, so an
    // asynchronous reset clears them as soon as state_q drops.
    always_comb begin
        state_d   = state_q;
        g_d       = g_q;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        req_ready = '0;
        grant     = '0;
        grant_id  = '0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    g_d     = win_idx;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                busy      = 1'b1;
                grant_id  = g_q;
                out_valid = own_valid;
                out_last  = own_last;
                out_data  = own_data;
                for (int i = 0; i < SENDER_NUM; i++) begin
                    if (g_q == IDX_WIDTH'(i)) begin
                        grant[i]     = 1'b1;
                        req_ready[i] = out_ready;
                    end
                end
                if (done) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // LRU update, applied only on a completion edge. The owner goes to the
    // bottom. Senders that ranked below it close the gap it leaves.
    always_comb begin
        for (int j = 0; j < SENDER_NUM; j++) begin
            rank_d[j] = rank_q[j];
            if (done) begin
                if (g_q == IDX_WIDTH'(j)) begin
                    rank_d[j] = IDX_WIDTH'(SENDER_NUM - 1);
                end else if (rank_q[j] > own_rank) begin
                    rank_d[j] = rank_q[j] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            g_q     <= '0;
            for (int j = 0; j < SENDER_NUM; j++) begin
                rank_q[j] <= IDX_WIDTH'(j);
            end
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            for (int j = 0; j < SENDER_NUM; j++) begin
                rank_q[j] <= rank_d[j];
            end
        end
    end

endmodule

// File: tb/tb_axi_burst_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi_burst_arbiter
//
// Directed bench for axi_burst_arbiter with SENDER_NUM=4 and DATA_WIDTH=32.
//
// Each sender is driven from its own beat queue by one driver process. A
// beat may carry a gap: a number of cycles for which valid stays low before
// that beat is presented. When the test issues beats, it also pushes the
// expected {grant_id, last, data} stream into exp_q, in the hand-derived
// arbitration order. A monitor pops exp_q on every output transfer and
// compares the two.
//
// Timing: the test acts at posedge+1 and the driver acts at posedge+2. All
// sampling happens on the falling edge.
// ---------------------------------------------------------------------------
module tb_axi_burst_arbiter;

    localparam int N    = 4;
    localparam int DW   = 32;
    localparam int IW   = 2;
    localparam int SB_W = IW + 1 + DW;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_last;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            out_valid;
    logic            out_last;
    logic [DW-1:0]   out_data;
    logic            out_ready;
    logic [N-1:0]    grant;
    logic [IW-1:0]   grant_id;
    logic            busy;

    always #5 clk = ~clk;

    axi_burst_arbiter #(
        .SENDER_NUM(N),
        .DATA_WIDTH(DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_data  (out_data),
        .out_ready (out_ready),
        .grant     (grant),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [SB_W-1:0] exp_q[$];

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic [3:0]    gap;
    } beat_t;

    beat_t      sq[N][$];
    logic [3:0] gap_cnt[N];
    logic       loaded[N];
    logic       rand_off = 1'b0;
    logic       drv_on   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_beat(input int s, input logic [DW-1:0] d, input logic l, input logic [3:0] gap);
        beat_t b;
        b.data = d;
        b.last = l;
        b.gap  = gap;
        sq[s].push_back(b);
    endtask

    task automatic expect_beat(input int s, input logic [DW-1:0] d, input logic l);
        exp_q.push_back({IW'(s), l, d});
    endtask

    task automatic flush_senders();
        for (int s = 0; s < N; s++) begin
            sq[s].delete();
            loaded[s]  = 1'b0;
            gap_cnt[s] = '0;
        end
    endtask

    function automatic bit senders_empty();
        for (int s = 0; s < N; s++) begin
            if (sq[s].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Wait, within a bounded number of cycles, until all traffic is
    // consumed and the arbiter is idle.
    task automatic drain(input string name);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy && senders_empty()) begin
                ok = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: drain timeout, %0d beats still expected, busy=%0b", name, exp_q.size(), busy);
        end
    endtask

    // ---------------- sender driver ----------------
    initial begin
        logic [N-1:0] hs;
        req_valid = N'($urandom);
        req_last  = N'($urandom);
        req_data  = {$urandom, $urandom, $urandom, $urandom};
        for (int s = 0; s < N; s++) begin
            loaded[s]  = 1'b0;
            gap_cnt[s] = '0;
        end
        wait (rand_off);
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        wait (drv_on);
        forever begin
            @(negedge clk);
            hs = req_valid & req_ready;
            @(posedge clk);
            #2;
            for (int s = 0; s < N; s++) begin
                if (hs[s] && sq[s].size() != 0) begin
                    sq[s].delete(0);
                    loaded[s] = 1'b0;
                end
                if (sq[s].size() != 0) begin
                    if (!loaded[s]) begin
                        gap_cnt[s] = sq[s][0].gap;
                        loaded[s]  = 1'b1;
                    end
                    if (gap_cnt[s] != 0) begin
                        req_valid[s] = 1'b0;
                        gap_cnt[s]   = gap_cnt[s] - 1'b1;
                    end else begin
                        req_valid[s] = 1'b1;
                    end
                    req_last[s]            = sq[s][0].last;
                    req_data[s*DW +: DW]   = sq[s][0].data;
                end else begin
                    req_valid[s]           = 1'b0;
                    req_last[s]            = 1'b0;
                    req_data[s*DW +: DW]   = '0;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_beat: got id=%0d last=%0b data=%0h, expected no beat",
                         grant_id, out_last, out_data);
            end else begin
                chk("beat", {grant_id, out_last, out_data}, exp_q.pop_front());
                chk("ready_route", req_ready, grant);
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed test ----------------
    initial begin
        logic [N-1:0] pg[5];
        logic [5:0]   rdy_pat;
        logic [5:0]   ov_pat;
        pg      = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rdy_pat = 6'b101101;   // out_ready per BUSY cycle: 1,0,1,1,0,1
        ov_pat  = 6'b110001;   // out_valid per BUSY cycle: 1,0,0,0,1,1

        // Reset with random inputs on every port.
        rst       = 1'b1;
        out_ready = 1'($urandom_range(0, 1));
        step();
        step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last",  out_last,  0);
        chk("rst_out_data",  out_data,  0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_grant",     grant,     0);
        chk("rst_grant_id",  grant_id,  0);
        chk("rst_busy",      busy,      0);
        rand_off  = 1'b1;
        out_ready = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_busy",  busy,  0);
        chk("post_rst_grant", grant, 0);
        @(negedge clk);
        chk("post_rst_idle",  busy,  0);
        step();
        drv_on = 1'b1;
        step();

        // Priority order: with reset ranks, the grants go 0,1,2,3 and then 0
        // again. Each grant is preceded by one idle cycle.
        step();
        for (int s = 0; s < N; s++) push_beat(s, 32'hA000_0000 + s, 1'b1, 4'd0);
        push_beat(0, 32'hA000_0004, 1'b1, 4'd0);
        for (int s = 0; s < N; s++) expect_beat(s, 32'hA000_0000 + s, 1'b1);
        expect_beat(0, 32'hA000_0004, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("prio_idle", busy, 0);
            @(negedge clk);
            chk("prio_grant", grant, pg[k]);
        end
        drain("prio");
        // ranks now {3,0,1,2}

        // Burst lock: sender 2 (rank 1) beats sender 0 (rank 3) and keeps the
        // channel for 4 beats while out_ready toggles.
        step();
        push_beat(0, 32'hB000_0000, 1'b1, 4'd0);
        for (int b = 1; b <= 4; b++) push_beat(2, 32'hC000_0000 + b, (b == 4), 4'd0);
        for (int b = 1; b <= 4; b++) expect_beat(2, 32'hC000_0000 + b, (b == 4));
        expect_beat(0, 32'hB000_0000, 1'b1);
        @(negedge clk);
        chk("lock_idle", busy, 0);
        for (int c = 0; c < 6; c++) begin
            step();
            out_ready = rdy_pat[c];
            @(negedge clk);
            chk("lock_grant", grant, 4'b0100);
            chk("lock_ready0", req_ready[0], 0);
        end
        step();
        out_ready = 1'b1;
        @(negedge clk);
        chk("lock_bubble", busy, 0);
        @(negedge clk);
        chk("lock_next_grant", grant, 4'b0001);
        drain("lock");
        // ranks now {3,0,2,1}

        // Owner bubble: sender 1 drops valid for 3 cycles mid-burst while
        // sender 3 waits.
        step();
        push_beat(1, 32'hD000_0001, 1'b0, 4'd0);
        push_beat(1, 32'hD000_0002, 1'b0, 4'd3);
        push_beat(1, 32'hD000_0003, 1'b1, 4'd0);
        push_beat(3, 32'hE000_0001, 1'b1, 4'd0);
        expect_beat(1, 32'hD000_0001, 1'b0);
        expect_beat(1, 32'hD000_0002, 1'b0);
        expect_beat(1, 32'hD000_0003, 1'b1);
        expect_beat(3, 32'hE000_0001, 1'b1);
        @(negedge clk);
        chk("gap_idle", busy, 0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("gap_grant", grant, 4'b0010);
            chk("gap_out_valid", out_valid, ov_pat[c]);
            chk("gap_ready3", req_ready[3], 0);
        end
        @(negedge clk);
        chk("gap_bubble", busy, 0);
        @(negedge clk);
        chk("gap_next_grant", grant, 4'b1000);
        drain("gap");

        // LRU update from reset ranks: after sender 2 completes, the ranks
        // are {0,1,3,2}, so sender 3 beats sender 2.
        step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        push_beat(2, 32'hF000_0001, 1'b1, 4'd0);
        expect_beat(2, 32'hF000_0001, 1'b1);
        drain("lru_first");
        step();
        push_beat(2, 32'hF000_0002, 1'b1, 4'd0);
        push_beat(3, 32'hF000_0003, 1'b1, 4'd0);
        expect_beat(3, 32'hF000_0003, 1'b1);
        expect_beat(2, 32'hF000_0002, 1'b1);
        @(negedge clk);
        chk("lru_idle", busy, 0);
        @(negedge clk);
        chk("lru_grant", grant, 4'b1000);
        drain("lru");
        // ranks now {0,1,3,2}

        // Move sender 0 to the bottom first ({3,0,2,1}), so that only a real
        // reset of the rank table lets sender 0 win afterwards.
        step();
        push_beat(0, 32'h1000_0000, 1'b1, 4'd0);
        expect_beat(0, 32'h1000_0000, 1'b1);
        drain("pre_abort");

        // Async reset during beat 2 of a 4-beat burst from sender 2.
        step();
        for (int b = 1; b <= 4; b++) push_beat(2, 32'h2000_0000 + b, (b == 4), 4'd0);
        expect_beat(2, 32'h2000_0001, 1'b0);
        @(negedge clk);
        chk("abort_idle", busy, 0);
        @(negedge clk);
        chk("abort_grant", grant, 4'b0100);
        step();
        #2;
        chk("abort_beat2_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_out_data",  out_data,  0);
        chk("abort_out_last",  out_last,  0);
        chk("abort_grant0",    grant,     0);
        chk("abort_grant_id",  grant_id,  0);
        chk("abort_busy",      busy,      0);
        chk("abort_req_ready", req_ready, 0);
        flush_senders();
        exp_q.delete();
        step();
        step();
        rst = 1'b0;
        step();
        for (int s = 0; s < N; s++) push_beat(s, 32'h3000_0000 + s, 1'b1, 4'd0);
        for (int s = 0; s < N; s++) expect_beat(s, 32'h3000_0000 + s, 1'b1);
        @(negedge clk);
        chk("after_abort_idle", busy, 0);
        @(negedge clk);
        chk("after_abort_grant", grant, 4'b0001);
        drain("after_abort");

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
